lm07_scan_reader: RTL and testbench

Parametrised multi-channel successor to the single-sensor LM07 reader. It polls up to `N_CH` LM07-style SPI temperature sensors round-robin over one shared `SIO` line. Each sensor has its own active-low chip select. The block keeps the last sample per channel, flags over-temperature per channel with sticky alarms, and reports which channel produced the newest sample. It sits between the sensor pins and the display/host logic, in place of the fixed 8-bit, single-channel reader.

---
 rtl/lm07_scan_reader.sv | 225 ++++++++++++++++++++++
 tb/tb_lm07_scan_reader.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/lm07_scan_reader.sv
// lm07_scan_reader
//   Polls up to N_CH LM07-style SPI temperature sensors round-robin over a
//   shared SIO line. The block keeps the last sample of each channel, flags
//   over-threshold samples with sticky per-channel alarms, and publishes the
//   newest sample together with the index of the channel that produced it.
//
// Ports
//   SYSCLK      system clock, rising edge
//   RSTN        asynchronous active-low reset
//   EN          scan enable; 1 keeps polling
//   SIO         shared serial data from the sensors
//   CS          per-sensor chip selects, active low, at most one low
//   SCK         serial clock, idles low
//   THRESH      signed alarm threshold shared by all channels
//   ALARM_CLR   clears all sticky alarms
//   RD_SEL      channel selector for RD_DATA
//   RD_DATA     last sample of channel RD_SEL (combinational read)
//   DATA        newest captured sample
//   DISP        channel index of DATA
//   DATA_VALID  one-cycle pulse when DATA/DISP update
//   ALARM       sticky per-channel over-threshold flags
//   BUSY        high while any CS is low
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | CS all high, SCK low, waiting for EN
// SETUP   | CS[ch] low, SCK low, SCK_DIV cycles before the first edge
// SHIFT_H | SCK high half-period; SIO captured on entry
// SHIFT_L | SCK low half-period between two bits
// HOLD    | SCK low after the last bit, CS still low, SCK_DIV cycles
// DONE    | CS high, sample published, one cycle
// GAP     | GAP_CYC idle cycles before the next frame

module lm07_scan_reader #(
    parameter int  N_CH    = 4,
    parameter int  DATA_W  = 16,
    parameter int  SCK_DIV = 4,
    parameter int  GAP_CYC = 8,
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              SYSCLK,
    input  logic              RSTN,
    input  logic              EN,
    input  logic              SIO,
    output logic [N_CH-1:0]   CS,
    output logic              SCK,
    input  logic [DATA_W-1:0] THRESH,
    input  logic              ALARM_CLR,
    input  logic [CH_W-1:0]   RD_SEL,
    output logic [DATA_W-1:0] RD_DATA,
    output logic [DATA_W-1:0] DATA,
    output logic [CH_W-1:0]   DISP,
    output logic              DATA_VALID,
    output logic [N_CH-1:0]   ALARM,
    output logic              BUSY
);

    localparam int TMR_MAX = (SCK_DIV > GAP_CYC) ? SCK_DIV : GAP_CYC;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam int BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [TMR_W-1:0] DIV_LD  = TMR_W'(SCK_DIV - 1);
    localparam logic [TMR_W-1:0] GAP_LD  = TMR_W'(GAP_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LD  = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST = CH_W'(N_CH - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETUP   = 3'd1,
        SHIFT_H = 3'd2,
        SHIFT_L = 3'd3,
        HOLD    = 3'd4,
        DONE    = 3'd5,
        GAP     = 3'd6
    } state_t;

    state_t            state;
    logic [TMR_W-1:0]  tmr;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [CH_W-1:0]   ch;
    logic [CH_W-1:0]   ch_next;
    logic [N_CH-1:0]   cs_sel;
    logic [N_CH-1:0]   alarm_set;
    logic              tmr_zero;
    logic              frame_end;
    logic [DATA_W-1:0] store [N_CH];

    always_comb begin
        tmr_zero  = (tmr == '0);
        frame_end = (state == HOLD) && tmr_zero;
        cs_sel    = ~(N_CH'(1) << ch);
        ch_next   = (ch == CH_LAST) ? '0 : ch + 1'b1;
        // The alarm is evaluated on the same edge that publishes the sample,
        // so it is set together with DATA_VALID.
        alarm_set = '0;
        if (frame_end && ($signed(shreg) > $signed(THRESH))) begin
            alarm_set = ~cs_sel;
        end
    end

    always_comb begin
        RD_DATA = '0;
        if (int'(RD_SEL) < N_CH) begin
            RD_DATA = store[RD_SEL];
        end
    end

    always_ff @(posedge SYSCLK or negedge RSTN) begin
        if (!RSTN) begin
            state      <= IDLE;
            tmr        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            ch         <= '0;
            CS         <= '1;
            SCK        <= 1'b0;
            BUSY       <= 1'b0;
            DATA       <= '0;
            DISP       <= '0;
            DATA_VALID <= 1'b0;
            ALARM      <= '0;
            for (int i = 0; i < N_CH; i++) begin
                store[i] <= '0;
            end
        end else begin
            DATA_VALID <= 1'b0;
            // A set on the publishing edge overrides a coincident clear.
            ALARM      <= (ALARM_CLR ? '0 : ALARM) | alarm_set;

            case (state)
                IDLE: begin
                    if (EN) begin
                        state <= SETUP;
                        CS    <= cs_sel;
                        BUSY  <= 1'b1;
                        tmr   <= DIV_LD;
                    end
                end

                SETUP: begin
                    if (tmr_zero) begin
                        state   <= SHIFT_H;
                        SCK     <= 1'b1;
                        shreg   <= {shreg[DATA_W-2:0], SIO};
                        bit_cnt <= BIT_LD;
                        tmr     <= DIV_LD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                SHIFT_H: begin
                    if (tmr_zero) begin
                        SCK <= 1'b0;
                        tmr <= DIV_LD;
                        // The low phase after the last bit is the HOLD period.
                        if (bit_cnt == '0) begin
                            state <= HOLD;
                        end else begin
                            state   <= SHIFT_L;
                            bit_cnt <= bit_cnt - 1'b1;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                SHIFT_L: begin
                    if (tmr_zero) begin
                        state <= SHIFT_H;
                        SCK   <= 1'b1;
                        shreg <= {shreg[DATA_W-2:0], SIO};
                        tmr   <= DIV_LD;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                HOLD: begin
                    if (tmr_zero) begin
                        state      <= DONE;
                        CS         <= '1;
                        BUSY       <= 1'b0;
                        DATA       <= shreg;
                        DISP       <= ch;
                        store[ch]  <= shreg;
                        DATA_VALID <= 1'b1;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                DONE: begin
                    state <= GAP;
                    tmr   <= GAP_LD;
                    ch    <= ch_next;
                end

                GAP: begin
                    if (tmr_zero) begin
                        if (EN) begin
                            state <= SETUP;
                            CS    <= cs_sel;
                            BUSY  <= 1'b1;
                            tmr   <= DIV_LD;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    CS    <= '1;
                    SCK   <= 1'b0;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lm07_scan_reader.sv
// Bench for lm07_scan_reader with default parameters: four behavioural
// sensors on the shared SIO line and directed checks of frame timing,
// round-robin order, alarms, EN drop and mid-frame reset.

module tb_lm07_scan_reader;

    logic        SYSCLK = 1'b0;
    logic        RSTN;
    logic        EN;
    logic        SIO = 1'b0;
    logic [3:0]  CS;
    logic        SCK;
    logic [15:0] THRESH;
    logic        ALARM_CLR;
    logic [1:0]  RD_SEL;
    logic [15:0] RD_DATA;
    logic [15:0] DATA;
    logic [1:0]  DISP;
    logic        DATA_VALID;
    logic [3:0]  ALARM;
    logic        BUSY;

    lm07_scan_reader dut (
        .SYSCLK     (SYSCLK),
        .RSTN       (RSTN),
        .EN         (EN),
        .SIO        (SIO),
        .CS         (CS),
        .SCK        (SCK),
        .THRESH     (THRESH),
        .ALARM_CLR  (ALARM_CLR),
        .RD_SEL     (RD_SEL),
        .RD_DATA    (RD_DATA),
        .DATA       (DATA),
        .DISP       (DISP),
        .DATA_VALID (DATA_VALID),
        .ALARM      (ALARM),
        .BUSY       (BUSY)
    );

    always #5 SYSCLK = ~SYSCLK;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int rise0  = 0;

    always @(posedge SYSCLK) cyc <= cyc + 1;
    always @(posedge SCK) if (!CS[0]) rise0 <= rise0 + 1;

    // Sensor model: MSB on CS fall, next bit on each SCK fall.
    logic [15:0] sens [4];
    logic [3:0]  cs_q  = 4'hF;
    logic        sck_q = 1'b0;
    int          bp    = 15;
    int          sch   = 0;

    always @(posedge SYSCLK) begin
        #1;
        if (cs_q == 4'hF && CS != 4'hF) begin
            for (int i = 0; i < 4; i++) if (!CS[i]) sch = i;
            bp  = 15;
            SIO = sens[sch][bp];
        end else if (sck_q && !SCK && CS != 4'hF) begin
            if (bp > 0) bp = bp - 1;
            SIO = sens[sch][bp];
        end
        cs_q  = CS;
        sck_q = SCK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge SYSCLK);
            n++;
        end while (!DATA_VALID && n < 400);
        if (!DATA_VALID) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_cs(input int idx, input string tag);
        int n = 0;
        do begin
            @(negedge SYSCLK);
            n++;
        end while (CS[idx] && n < 400);
        if (CS[idx]) check_val({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    int t0;
    int last;
    int bad;

    initial begin
        RSTN = 1'b0; EN = 1'b0; ALARM_CLR = 1'b0; RD_SEL = 2'd0; THRESH = 16'h7FFF;
        sens[0] = 16'h0C80; sens[1] = 16'h0200; sens[2] = 16'h0300; sens[3] = 16'h0400;

        repeat (3) @(negedge SYSCLK);
        check_val("rst_cs",    {28'd0, CS},    32'hF);
        check_val("rst_sck",   {31'd0, SCK},   32'd0);
        check_val("rst_busy",  {31'd0, BUSY},  32'd0);
        check_val("rst_data",  {16'd0, DATA},  32'd0);
        check_val("rst_disp",  {30'd0, DISP},  32'd0);
        check_val("rst_valid", {31'd0, DATA_VALID}, 32'd0);
        check_val("rst_alarm", {28'd0, ALARM}, 32'd0);

        RSTN = 1'b1;
        @(negedge SYSCLK);
        check_val("idle_cs", {28'd0, CS}, 32'hF);

        // Single frame, default timing.
        EN = 1'b1;
        @(negedge SYSCLK);
        t0 = cyc;
        check_val("f0_cs_low", {28'd0, CS},   32'hE);
        check_val("f0_busy",   {31'd0, BUSY}, 32'd1);
        wait_valid("f0");
        check_val("f0_t",     cyc - t0,       32'd132);
        check_val("f0_data",  {16'd0, DATA},  32'h0C80);
        check_val("f0_disp",  {30'd0, DISP},  32'd0);
        check_val("f0_rises", rise0,          32'd16);
        check_val("f0_cs_hi", {28'd0, CS},    32'hF);
        last = cyc;

        // Round-robin with wrap; alarms against 0x0200.
        THRESH  = 16'h0200;
        sens[0] = 16'h0100;
        for (int k = 1; k <= 4; k++) begin
            wait_valid("rr");
            check_val($sformatf("rr%0d_disp", k), {30'd0, DISP}, k % 4);
            check_val($sformatf("rr%0d_data", k), {16'd0, DATA}, {16'd0, sens[k % 4]});
            check_val($sformatf("rr%0d_gap", k),  cyc - last,    32'd141);
            last = cyc;
        end
        check_val("alarm_scan", {28'd0, ALARM}, 32'hC);
        RD_SEL = 2'd2; #1;
        check_val("rd_ch2", {16'd0, RD_DATA}, 32'h0300);
        RD_SEL = 2'd0; #1;
        check_val("rd_ch0", {16'd0, RD_DATA}, 32'h0100);
        RD_SEL = 2'd3; #1;
        check_val("rd_ch3", {16'd0, RD_DATA}, 32'h0400);

        // Clear, then the bits come back on the next scan.
        @(negedge SYSCLK);
        ALARM_CLR = 1'b1;
        @(negedge SYSCLK);
        ALARM_CLR = 1'b0;
        check_val("alarm_clr", {28'd0, ALARM}, 32'h0);
        repeat (3) wait_valid("reset_scan");
        check_val("alarm_again_disp", {30'd0, DISP}, 32'd3);
        check_val("alarm_again",      {28'd0, ALARM}, 32'hC);

        // Equality does not alarm.
        THRESH = 16'h0400;
        ALARM_CLR = 1'b1;
        @(negedge SYSCLK);
        ALARM_CLR = 1'b0;
        repeat (4) wait_valid("eq_scan");
        check_val("eq_disp",  {30'd0, DISP},  32'd3);
        check_val("eq_alarm", {28'd0, ALARM}, 32'h0);

        // Signed compare.
        sens[0] = 16'hFF80;
        THRESH  = 16'hFF00;
        wait_valid("neg0");
        check_val("neg_data",   {16'd0, DATA},  32'hFF80);
        check_val("neg_alarm0", {28'd0, ALARM}, 32'h1);
        wait_valid("neg1");
        check_val("neg_alarm1", {28'd0, ALARM}, 32'h3);

        // EN dropped at t=40 of channel 2's frame.
        wait_cs(2, "en_cs2");
        repeat (40) @(negedge SYSCLK);
        EN = 1'b0;
        wait_valid("en_drop");
        check_val("en_drop_disp", {30'd0, DISP}, 32'd2);
        check_val("en_drop_data", {16'd0, DATA}, 32'h0300);
        bad = 0;
        repeat (300) begin
            @(negedge SYSCLK);
            if (CS != 4'hF || BUSY || DATA_VALID) bad++;
        end
        check_val("en_idle_quiet", bad, 32'd0);
        EN = 1'b1;
        @(negedge SYSCLK);
        check_val("en_resume_cs", {28'd0, CS}, 32'h7);
        wait_valid("en_resume");
        check_val("en_resume_disp", {30'd0, DISP}, 32'd3);
        check_val("en_resume_data", {16'd0, DATA}, 32'h0400);

        // Asynchronous reset at t=70 of channel 0's frame.
        wait_cs(0, "rst_cs0");
        repeat (70) @(negedge SYSCLK);
        RSTN = 1'b0;
        #1;
        check_val("mrst_cs",    {28'd0, CS},    32'hF);
        check_val("mrst_sck",   {31'd0, SCK},   32'd0);
        check_val("mrst_busy",  {31'd0, BUSY},  32'd0);
        check_val("mrst_data",  {16'd0, DATA},  32'd0);
        check_val("mrst_disp",  {30'd0, DISP},  32'd0);
        check_val("mrst_alarm", {28'd0, ALARM}, 32'd0);
        RD_SEL = 2'd3; #1;
        check_val("mrst_store", {16'd0, RD_DATA}, 32'd0);
        bad = 0;
        repeat (3) begin
            @(negedge SYSCLK);
            if (DATA_VALID) bad++;
        end
        check_val("mrst_no_valid", bad, 32'd0);
        RSTN = 1'b1;
        @(negedge SYSCLK);
        check_val("mrst_restart_cs", {28'd0, CS}, 32'hE);
        wait_valid("mrst_frame");
        check_val("mrst_frame_disp", {30'd0, DISP}, 32'd0);
        check_val("mrst_frame_data", {16'd0, DATA}, 32'hFF80);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
